// File: rtl/life_scheduler_pkg.sv
// Shared types and widths for the generation scheduler and its neighbours.
package life_scheduler_pkg;

    localparam int LOG_MAX_SPEED = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        SWAP
    } sched_state_t;

endpackage

// File: rtl/life_scheduler.sv
// Per-frame generation scheduler: launches one life_logic pass per accepted
// frame tick, applies pause/step policy via speed_out and flips the display buffer.
module life_scheduler
    import life_scheduler_pkg::*;
#(
    parameter int DONE_GUARD = 4,
    parameter int GEN_W      = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     frame_tick_in,
    input  logic                     pause_in,
    input  logic                     step_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     logic_done_in,
    input  logic                     clr_overrun_in,
    output logic                     start_out,
    output logic [LOG_MAX_SPEED-1:0] speed_out,
    output logic                     swap_out,
    output logic                     busy_out,
    output logic [GEN_W-1:0]         gen_count_out,
    output logic                     overrun_out
);

    localparam int                  GUARD_W    = $clog2(DONE_GUARD + 1);
    localparam logic [GUARD_W-1:0]  GUARD_LOAD = GUARD_W'(DONE_GUARD - 1);

    sched_state_t       state;
    logic [GUARD_W-1:0] guard_cnt;
    logic               step_pending;

    // NOTE: every output is a flop; start_out is defaulted low at the top of the
    // clocked branch so it can only ever be a one-cycle pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            guard_cnt     <= '0;
            step_pending  <= 1'b0;
            start_out     <= 1'b0;
            speed_out     <= '0;
            swap_out      <= 1'b0;
            busy_out      <= 1'b0;
            gen_count_out <= '0;
            overrun_out   <= 1'b0;
        end else begin
            start_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_tick_in && logic_done_in) begin
                        state     <= START;
                        start_out <= 1'b1;
                        busy_out  <= 1'b1;
                    end
                end
                START: begin
                    if (!pause_in) begin
                        speed_out <= speed_in;
                    end else if (step_pending) begin
                        speed_out    <= '1;
                        step_pending <= 1'b0;
                    end else begin
                        speed_out <= '0;
                    end
                    guard_cnt <= GUARD_LOAD;
                    state     <= RUN;
                end
                RUN: begin
                    // done may still be high from the previous pass until life_logic reacts
                    if (guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end else if (logic_done_in) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    swap_out      <= ~swap_out;
                    gen_count_out <= gen_count_out + 1'b1;
                    busy_out      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A fresh step request outranks consumption of the previous one.
            if (!pause_in) begin
                step_pending <= 1'b0;
            end else if (step_in) begin
                step_pending <= 1'b1;
            end

            if (frame_tick_in && (state != IDLE || !logic_done_in)) begin
                overrun_out <= 1'b1;
            end else if (clr_overrun_in) begin
                overrun_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_life_scheduler.sv
// Scoreboard bench for life_scheduler: stimulus queues expected START/SWAP
// events, a monitor matches them against what the DUT presents.
module tb_life_scheduler;
    import life_scheduler_pkg::*;

    typedef enum int {EV_START, EV_SWAP} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       val;
        int       val2;
    } ev_t;

    logic                     clk_in = 1'b0;
    logic                     rst_n_in;
    logic                     frame_tick_in;
    logic                     pause_in;
    logic                     step_in;
    logic [LOG_MAX_SPEED-1:0] speed_in;
    logic                     logic_done_in;
    logic                     clr_overrun_in;
    logic                     start_out;
    logic [LOG_MAX_SPEED-1:0] speed_out;
    logic                     swap_out;
    logic                     busy_out;
    logic [3:0]               gen_count_out;
    logic                     overrun_out;

    int  cyc = 0;
    int  vectors = 0;
    int  misses = 0;
    ev_t sb_q[$];

    logic       exp_swap = 1'b0;
    logic [3:0] exp_gen  = 4'd0;

    life_scheduler #(
        .DONE_GUARD(4),
        .GEN_W     (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .frame_tick_in (frame_tick_in),
        .pause_in      (pause_in),
        .step_in       (step_in),
        .speed_in      (speed_in),
        .logic_done_in (logic_done_in),
        .clr_overrun_in(clr_overrun_in),
        .start_out     (start_out),
        .speed_out     (speed_out),
        .swap_out      (swap_out),
        .busy_out      (busy_out),
        .gen_count_out (gen_count_out),
        .overrun_out   (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_t kind, input int c, input int v, input int v2);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        e.val2 = v2;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_t kind, input int c, input int v, input int v2);
        ev_t e;
        if (sb_q.size() == 0) begin
            vectors++;
            misses++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, c);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", kind, e.kind);
            check(kind == EV_START ? "start_cycle" : "swap_cycle", c, e.cyc);
            check(kind == EV_START ? "speed_out" : "swap_out", v, e.val);
            if (kind == EV_SWAP) check("gen_count_out", v2, e.val2);
        end
    endtask

    // Monitor: a start pulse is reported with the speed latched one cycle later;
    // every swap_out toggle is reported with the generation count.
    initial begin
        logic prev_swap;
        logic start_pending;
        int   start_cyc;
        prev_swap     = 1'b0;
        start_pending = 1'b0;
        start_cyc     = 0;
        forever begin
            @(negedge clk_in or negedge rst_n_in);
            if (!rst_n_in) begin
                prev_swap     = 1'b0;
                start_pending = 1'b0;
            end else begin
                if (start_pending) begin
                    pop_check(EV_START, start_cyc, int'(speed_out), 0);
                    start_pending = 1'b0;
                end
                if (start_out === 1'b1) begin
                    start_pending = 1'b1;
                    start_cyc     = cyc;
                end
                if (swap_out !== prev_swap) begin
                    prev_swap = swap_out;
                    pop_check(EV_SWAP, cyc, int'(swap_out), int'(gen_count_out));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One pass with done held high: start at T+1, SWAP state at T+6, visible at T+7.
    task automatic run_pass(input int exp_speed, input bit extra_tick, input bit clr_same);
        int t;
        t        = cyc;
        exp_swap = ~exp_swap;
        exp_gen  = exp_gen + 4'd1;
        push_ev(EV_START, t + 1, exp_speed, 0);
        push_ev(EV_SWAP, t + 7, int'(exp_swap), int'(exp_gen));
        frame_tick_in = 1'b1;
        step(1);
        frame_tick_in = 1'b0;
        step(2);
        if (extra_tick) begin
            frame_tick_in  = 1'b1;
            clr_overrun_in = clr_same;
        end
        step(1);
        frame_tick_in  = 1'b0;
        clr_overrun_in = 1'b0;
        step(3);
    endtask

    task automatic pulse_step();
        step_in = 1'b1;
        step(1);
        step_in = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_overrun_in = 1'b1;
        step(1);
        clr_overrun_in = 1'b0;
    endtask

    initial begin
        int t;
        rst_n_in       = 1'b0;
        frame_tick_in  = 1'b0;
        pause_in       = 1'b0;
        step_in        = 1'b0;
        speed_in       = 4'd5;
        logic_done_in  = 1'b1;
        clr_overrun_in = 1'b0;

        // Reset values
        step(3);
        check("rst_start", start_out, 0);
        check("rst_speed", speed_out, 0);
        check("rst_swap", swap_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_gen", gen_count_out, 0);
        check("rst_overrun", overrun_out, 0);
        #2 rst_n_in = 1'b1;
        step(1);

        // Normal pass: done drops at T+2, returns at T+20
        t        = cyc;
        exp_swap = 1'b1;
        exp_gen  = 4'd1;
        push_ev(EV_START, t + 1, 5, 0);
        push_ev(EV_SWAP, t + 22, 1, 1);
        frame_tick_in = 1'b1;
        step(1);
        frame_tick_in = 1'b0;
        step(1);
        logic_done_in = 1'b0;
        check("busy_in_run", busy_out, 1);
        step(18);
        logic_done_in = 1'b1;
        step(1);
        check("busy_in_swap", busy_out, 1);
        step(1);
        check("busy_after_swap", busy_out, 0);

        // Guard window: done held high, back-to-back passes
        run_pass(5, 1'b0, 1'b0);
        run_pass(5, 1'b0, 1'b0);

        // Overrun: tick while done low in IDLE
        logic_done_in = 1'b0;
        frame_tick_in = 1'b1;
        step(1);
        frame_tick_in = 1'b0;
        logic_done_in = 1'b1;
        check("overrun_idle_tick", overrun_out, 1);
        check("idle_tick_no_busy", busy_out, 0);
        pulse_clr();
        check("overrun_cleared", overrun_out, 0);

        // Overrun: tick during RUN, sticky, then cleared
        run_pass(5, 1'b1, 1'b0);
        check("overrun_run_tick", overrun_out, 1);
        step(3);
        check("overrun_sticky", overrun_out, 1);
        pulse_clr();
        check("overrun_cleared2", overrun_out, 0);
        run_pass(5, 1'b1, 1'b1);
        check("overrun_set_wins", overrun_out, 1);
        pulse_clr();
        check("overrun_cleared3", overrun_out, 0);

        // Pause and step
        pause_in = 1'b1;
        run_pass(0, 1'b0, 1'b0);
        pulse_step();
        step(2);
        pulse_step();
        run_pass(15, 1'b0, 1'b0);
        run_pass(0, 1'b0, 1'b0);
        pause_in = 1'b0;
        pulse_step();
        pause_in = 1'b1;
        run_pass(0, 1'b0, 1'b0);
        pulse_step();
        pause_in = 1'b0;
        step(1);
        pause_in = 1'b1;
        run_pass(0, 1'b0, 1'b0);
        pause_in = 1'b0;
        run_pass(5, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN
        t = cyc;
        push_ev(EV_START, t + 1, 5, 0);
        frame_tick_in = 1'b1;
        step(1);
        frame_tick_in = 1'b0;
        step(1);
        frame_tick_in = 1'b1;
        step(1);
        frame_tick_in = 1'b0;
        check("busy_before_reset", busy_out, 1);
        check("overrun_before_reset", overrun_out, 1);
        #3 rst_n_in = 1'b0;
        #1;
        check("arst_start", start_out, 0);
        check("arst_speed", speed_out, 0);
        check("arst_swap", swap_out, 0);
        check("arst_busy", busy_out, 0);
        check("arst_gen", gen_count_out, 0);
        check("arst_overrun", overrun_out, 0);
        exp_swap = 1'b0;
        exp_gen  = 4'd0;
        @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        step(1);

        // Counter wrap: 17 passes from reset
        repeat (17) run_pass(5, 1'b0, 1'b0);
        check("wrap_gen", gen_count_out, 1);
        check("wrap_swap", swap_out, 1);

        step(4);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
